// File: rtl/riscv_mem_avmm_bridge.sv
// picorv32 native memory port to NUM_CH Avalon-MM masters, one transaction at a time,
// with unmapped-region and timeout error completion and stale read-beat discard.
module riscv_mem_avmm_bridge #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned SEL_W          = 1,
  parameter int unsigned AVM_ADDR_W     = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_valid,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic [3:0]                   mem_wstrb,
  output logic                         mem_ready,
  output logic [31:0]                  mem_rdata,
  output logic [NUM_CH*AVM_ADDR_W-1:0] avm_address,
  output logic [NUM_CH-1:0]            avm_read,
  output logic [NUM_CH-1:0]            avm_write,
  output logic [NUM_CH*32-1:0]         avm_writedata,
  output logic [NUM_CH*4-1:0]          avm_byteenable,
  input  logic [NUM_CH-1:0]            avm_waitrequest,
  input  logic [NUM_CH-1:0]            avm_readdatavalid,
  input  logic [NUM_CH*32-1:0]         avm_readdata,
  output logic                         err,
  output logic [31:0]                  err_addr,
  input  logic                         err_clr
);

  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;
  state_t state, next_state;

  logic [31:0]       addr_q;
  logic [3:0]        wstrb_q;
  logic [SEL_W-1:0]  ch_q;
  logic [NUM_CH-1:0] stale;
  logic [31:0]       cnt;

  logic [SEL_W-1:0]  req_ch;
  logic              req_unmapped;
  logic              is_rd;
  logic              wait_sel, rdv_sel, stale_sel, rdv_good;
  logic [31:0]       rdata_sel;
  logic              tmo_hit;
  logic              accept, capture, abort, unmapped_hit, err_hit;
  logic [31:0]       err_src;

  assign req_ch       = mem_addr[31 -: SEL_W];
  assign req_unmapped = 32'(req_ch) >= NUM_CH;
  assign is_rd        = ~|wstrb_q;
  assign rdv_good     = rdv_sel & ~stale_sel;
  assign tmo_hit      = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 1);
  assign err_hit      = unmapped_hit | abort;
  assign err_src      = (state == IDLE) ? mem_addr : addr_q;

  always_comb begin
    wait_sel  = 1'b0;
    rdv_sel   = 1'b0;
    stale_sel = 1'b0;
    rdata_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (32'(ch_q) == c) begin
        wait_sel  = avm_waitrequest[c];
        rdv_sel   = avm_readdatavalid[c];
        stale_sel = stale[c];
        rdata_sel = avm_readdata[c*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    capture      = 1'b0;
    abort        = 1'b0;
    unmapped_hit = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          if (req_unmapped) begin
            unmapped_hit = 1'b1;
            next_state   = DONE;
          end else begin
            accept     = 1'b1;
            next_state = CMD;
          end
        end
      end
      CMD: begin
        if (!wait_sel && !is_rd) begin
          next_state = DONE;
        end else if (!wait_sel && rdv_good) begin
          capture    = 1'b1;
          next_state = DONE;
        end else begin
          if (!wait_sel) next_state = RESP;
          if (tmo_hit) begin
            abort      = 1'b1;
            next_state = DONE;
          end
        end
      end
      RESP: begin
        if (rdv_good) begin
          capture    = 1'b1;
          next_state = DONE;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (mem_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // mem_ready pulses on the first cycle spent in DONE that has not pulsed yet; an
  // unmapped request enters DONE straight from IDLE and so pulses on its second DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready      <= 1'b0;
      mem_rdata      <= '0;
      addr_q         <= '0;
      wstrb_q        <= '0;
      ch_q           <= '0;
      stale          <= '0;
      cnt            <= '0;
      err            <= 1'b0;
      err_addr       <= '0;
      avm_address    <= '0;
      avm_read       <= '0;
      avm_write      <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
    end else begin
      mem_ready <= (state != IDLE) && (next_state == DONE) && !mem_ready;

      if (state == IDLE && mem_valid) begin
        addr_q  <= mem_addr;
        wstrb_q <= mem_wstrb;
        ch_q    <= req_ch;
      end

      if (capture)      mem_rdata <= rdata_sel;
      else if (err_hit) mem_rdata <= ERR_RDATA;

      if (err_hit) begin
        err <= 1'b1;
        if (!err) err_addr <= err_src;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (abort && is_rd && 32'(ch_q) == c) stale[c] <= 1'b1;
        else if (avm_readdatavalid[c])        stale[c] <= 1'b0;
      end

      if (accept)                            cnt <= '0;
      else if (state == CMD || state == RESP) cnt <= cnt + 32'd1;

      if (accept) begin
        avm_address    <= '0;
        avm_read       <= '0;
        avm_write      <= '0;
        avm_writedata  <= '0;
        avm_byteenable <= '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (32'(req_ch) == c) begin
            avm_address[c*AVM_ADDR_W +: AVM_ADDR_W] <= mem_addr[AVM_ADDR_W-1:0];
            avm_read[c]                            <= (mem_wstrb == 4'h0);
            avm_write[c]                           <= (mem_wstrb != 4'h0);
            avm_writedata[c*32 +: 32]              <= mem_wdata;
            avm_byteenable[c*4 +: 4]               <= (mem_wstrb == 4'h0) ? 4'hF : mem_wstrb;
          end
        end
      end else if (state == CMD && next_state != CMD) begin
        avm_read  <= '0;
        avm_write <= '0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_avmm_bridge.sv
// Bench for riscv_mem_avmm_bridge: Avalon slave model, request driver and a
// completion scoreboard of expected mem_rdata values.
module tb_riscv_mem_avmm_bridge;
  localparam int NCH = 3;
  localparam int AW  = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_valid;
  logic [31:0]       mem_addr, mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [NCH*AW-1:0] avm_address;
  logic [NCH-1:0]    avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [NCH*32-1:0] avm_writedata, avm_readdata;
  logic [NCH*4-1:0]  avm_byteenable;
  logic              err;
  logic [31:0]       err_addr;
  logic              err_clr;

  riscv_mem_avmm_bridge #(
    .NUM_CH(3), .SEL_W(2), .AVM_ADDR_W(24), .TIMEOUT_CYCLES(16), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata),
    .err(err), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave model configuration and observation
  int          cfg_wait, cfg_lat, cfg_beats;
  bit          cfg_silent[NCH];
  logic [31:0] rd_val[NCH];
  int          inj_ch;
  logic [31:0] inj_val;
  int          str_cnt[NCH], wait_cnt[NCH], rdv_cnt[NCH], beats_left[NCH];
  logic [31:0] beat_val[NCH];
  logic [AW-1:0] acc_addr[NCH];
  logic [3:0]  acc_be[NCH];
  logic [31:0] acc_wd[NCH];
  bit          held[NCH];
  logic [61:0] held_val[NCH];
  logic [61:0] slv_cur;

  task automatic next_beat(input int c);
    avm_readdatavalid[c]      = 1'b1;
    avm_readdata[c*32 +: 32]  = beat_val[c];
    beat_val[c]               = beat_val[c] + 32'd1;
    beats_left[c]             = beats_left[c] - 1;
    if (beats_left[c] > 0) rdv_cnt[c] = 1;
  endtask

  initial begin
    avm_waitrequest   = '0;
    avm_readdatavalid = '0;
    avm_readdata      = '0;
    for (int c = 0; c < NCH; c++) begin
      str_cnt[c] = 0; wait_cnt[c] = 0; rdv_cnt[c] = 0; beats_left[c] = 0; held[c] = 0;
    end
    forever begin
      @(posedge clk); #1;
      avm_readdatavalid = '0;
      for (int c = 0; c < NCH; c++) begin
        slv_cur = {avm_read[c], avm_write[c], avm_byteenable[c*4 +: 4],
                   avm_writedata[c*32 +: 32], avm_address[c*AW +: AW]};
        if (inj_ch == c) begin
          avm_readdatavalid[c]     = 1'b1;
          avm_readdata[c*32 +: 32] = inj_val;
          inj_ch = -1;
        end
        if (rdv_cnt[c] > 0) begin
          rdv_cnt[c] = rdv_cnt[c] - 1;
          if (rdv_cnt[c] == 0) next_beat(c);
        end
        if (avm_read[c] || avm_write[c]) begin
          str_cnt[c]++;
          if (held[c]) check("cmd_hold", slv_cur, held_val[c]);
          if (wait_cnt[c] < cfg_wait) begin
            wait_cnt[c]++;
            avm_waitrequest[c] = 1'b1;
            held[c] = 1;
            held_val[c] = slv_cur;
          end else begin
            avm_waitrequest[c] = 1'b0;
            held[c] = 0;
            wait_cnt[c] = 0;
            acc_addr[c] = avm_address[c*AW +: AW];
            acc_be[c]   = avm_byteenable[c*4 +: 4];
            acc_wd[c]   = avm_writedata[c*32 +: 32];
            if (avm_read[c] && !cfg_silent[c]) begin
              beats_left[c] = cfg_beats;
              beat_val[c]   = rd_val[c];
              if (cfg_lat == 0) next_beat(c);
              else rdv_cnt[c] = cfg_lat;
            end
          end
        end else begin
          avm_waitrequest[c] = 1'b0;
          held[c] = 0;
          wait_cnt[c] = 0;
        end
      end
    end
  end

  // completion monitor: every mem_ready pops one expected read-data value
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        if (sb_q.size() == 0) check("spurious_ready", 1'b1, 1'b0);
        else begin
          e = sb_q.pop_front();
          check("rdata", mem_rdata, e);
        end
      end
    end
  end

  task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] exp, input int exp_lat,
                        input bit clr);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    for (int c = 0; c < NCH; c++) str_cnt[c] = 0;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws; err_clr = clr;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (n == 1) err_clr = 1'b0;
      if (mem_ready) begin
        got = 1;
        lat = n;
      end
    end
    mem_valid = 1'b0;
    err_clr   = 1'b0;
    check({tag, "_ready"}, got, 1'b1);
    check({tag, "_lat"}, lat, exp_lat);
    if (!got) void'(sb_q.pop_back());
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_valid = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0; err_clr = 0;
    cfg_wait = 0; cfg_lat = 1; cfg_beats = 1; inj_ch = -1; inj_val = '0;
    for (int c = 0; c < NCH; c++) begin
      cfg_silent[c] = 0;
      rd_val[c] = '0;
    end
    repeat (3) @(posedge clk); #1;
    check("rst_ready", mem_ready, 1'b0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_strobes", {avm_read, avm_write}, '0);
    check("rst_addr", avm_address, '0);
    check("rst_be", avm_byteenable, '0);
    check("rst_err", {err, err_addr}, '0);
    @(negedge clk); rst_n = 1'b1;

    // write with three waitrequest cycles on channel 2
    cfg_wait = 3;
    do_req("wr_wait", 32'h8000_0010, 32'hCAFE_F00D, 4'h3, 32'h0, 5, 0);
    check("wr_wait_strobes", str_cnt[2], 4);
    check("wr_wait_addr", acc_addr[2], 24'h00_0010);
    check("wr_wait_be", acc_be[2], 4'h3);
    check("wr_wait_wd", acc_wd[2], 32'hCAFE_F00D);
    check("wr_wait_other", str_cnt[0] + str_cnt[1], 0);
    cfg_wait = 0;

    // reads with response latencies 2, 1, 0
    cfg_lat = 2; rd_val[0] = 32'h1234_5678;
    do_req("rd_lat2", 32'h0000_0100, 32'h0, 4'h0, 32'h1234_5678, 4, 0);
    check("rd_lat2_strobes", str_cnt[0], 1);
    check("rd_lat2_be", acc_be[0], 4'hF);
    check("rd_lat2_addr", acc_addr[0], 24'h00_0100);
    cfg_lat = 1; rd_val[1] = 32'h0BAD_F00D;
    do_req("rd_lat1", 32'h4000_0200, 32'h0, 4'h0, 32'h0BAD_F00D, 3, 0);
    cfg_lat = 0; rd_val[2] = 32'h600D_CAFE;
    do_req("rd_lat0", 32'h8000_0300, 32'h0, 4'h0, 32'h600D_CAFE, 2, 0);
    cfg_lat = 1;

    // zero-wait write keeps the last read value on mem_rdata
    do_req("wr_zw", 32'h0000_0020, 32'h55AA_33CC, 4'hC, 32'h600D_CAFE, 2, 0);
    check("wr_zw_be", acc_be[0], 4'hC);
    check("wr_zw_wd", acc_wd[0], 32'h55AA_33CC);

    // unmapped accesses: first error address is sticky
    do_req("unmap_rd", 32'hC000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 2, 0);
    check("unmap_bus", str_cnt[0] + str_cnt[1] + str_cnt[2], 0);
    check("unmap_err", err, 1'b1);
    check("unmap_err_addr", err_addr, 32'hC000_0000);
    do_req("unmap_wr", 32'hC000_0040, 32'h1, 4'hF, 32'hDEAD_BEEF, 2, 0);
    check("unmap2_err_addr", err_addr, 32'hC000_0000);
    pulse_clr();
    check("clr_err", err, 1'b0);
    check("clr_err_addr", err_addr, 32'hC000_0000);

    // timeout on a silent channel, then a late beat that must be discarded
    cfg_silent[1] = 1;
    do_req("tmo", 32'h4000_0008, 32'h0, 4'h0, 32'hDEAD_BEEF, 17, 0);
    check("tmo_err", err, 1'b1);
    check("tmo_err_addr", err_addr, 32'h4000_0008);
    check("tmo_strobes", str_cnt[1], 1);
    check("tmo_idle_bus", {avm_read, avm_write}, '0);
    cfg_silent[1] = 0;
    @(negedge clk); inj_ch = 1; inj_val = 32'h1111_1111;
    repeat (3) @(negedge clk);
    rd_val[1] = 32'hAAAA_5555;
    do_req("post_stale", 32'h4000_000C, 32'h0, 4'h0, 32'hAAAA_5555, 3, 0);

    // second timeout; next read's first beat is the stale one
    cfg_silent[1] = 1;
    do_req("tmo2", 32'h4000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 17, 0);
    check("tmo2_err_addr", err_addr, 32'h4000_0008);
    cfg_silent[1] = 0;
    cfg_beats = 2; rd_val[1] = 32'h2000_0000;
    do_req("stale_beat", 32'h4000_0014, 32'h0, 4'h0, 32'h2000_0001, 4, 0);
    cfg_beats = 1;

    // new error in the same cycle as err_clr: set wins
    pulse_clr();
    check("clr2_err", err, 1'b0);
    do_req("set_vs_clr", 32'hC000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, 2, 1);
    check("set_vs_clr_err", err, 1'b1);
    check("set_vs_clr_addr", err_addr, 32'hC000_0100);

    // asynchronous reset while waiting for a read response
    cfg_silent[0] = 1;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 32'h0000_0040; mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("arst_ready", mem_ready, 1'b0);
    check("arst_rdata", mem_rdata, 32'h0);
    check("arst_strobes", {avm_read, avm_write}, '0);
    check("arst_bus", {avm_address, avm_byteenable}, '0);
    check("arst_err", {err, err_addr}, '0);
    mem_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; cfg_silent[0] = 0;
    repeat (2) @(negedge clk);
    rd_val[0] = 32'h5A5A_A5A5;
    do_req("after_rst", 32'h0000_0044, 32'h0, 4'h0, 32'h5A5A_A5A5, 3, 0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
